// File: rtl/csc_pkg.sv
// Shared constants and types for the YUV-to-RGB converter.
// Coefficients are 16.16 fixed point.
package csc_pkg;

    localparam int COEF_Y  = 76284;
    localparam int COEF_RV = 104595;
    localparam int COEF_GU = 25624;
    localparam int COEF_GV = 53281;
    localparam int COEF_BU = 132251;

    localparam int Y_OFS = 16;
    localparam int C_OFS = 128;

    typedef logic signed [31:0] acc_t;
    typedef logic signed [8:0]  smp_t;

    function automatic smp_t centre(input logic [7:0] x, input smp_t ofs);
        return smp_t'({1'b0, x}) - ofs;
    endfunction

endpackage

// File: rtl/csc_yuv2rgb_pipe_if.sv
// Pixel-in / pixel-out handshake bundle for csc_yuv2rgb_pipe.
// Master side is the producer/consumer pair, slave side is the converter.
interface csc_yuv2rgb_pipe_if #(
    parameter int CNT_W = 17
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_Y;
    logic [7:0]       in_U;
    logic [7:0]       in_V;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_R;
    logic [7:0]       out_G;
    logic [7:0]       out_B;
    logic             frame_done;
    logic [CNT_W-1:0] pixel_count;

    modport slave (
        input  in_valid, in_Y, in_U, in_V, out_ready,
        output in_ready, out_valid, out_R, out_G, out_B,
        output frame_done, pixel_count
    );

    modport master (
        output in_valid, in_Y, in_U, in_V, out_ready,
        input  in_ready, out_valid, out_R, out_G, out_B,
        input  frame_done, pixel_count
    );
endinterface

// File: rtl/csc_clip_u8.sv
// Saturates a signed 16.16 accumulator to an unsigned 8-bit channel.
// Negative -> 0, >= 256.0 -> 255, else integer part (truncated).
module csc_clip_u8
    import csc_pkg::*;
(
    input  acc_t       sum,
    output logic [7:0] q
);
    always_comb begin
        q = sum[23:16];
        if (sum[31]) begin
            q = 8'd0;
        end else if (|sum[30:24]) begin
            q = 8'd255;
        end
    end
endmodule

// File: rtl/csc_yuv2rgb_pipe.sv
// Three-stage YUV-to-RGB converter with whole-pipe stall and a
// per-frame output pixel counter.
module csc_yuv2rgb_pipe
    import csc_pkg::*;
#(
    parameter int PIXELS_PER_FRAME = 76800,
    parameter int CNT_W            = 17
) (
    input logic               Clock_50,
    input logic               Resetn,
    csc_yuv2rgb_pipe_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PIXELS_PER_FRAME - 1);

    logic       advance;
    logic       s1_valid;
    smp_t       s1_y;
    smp_t       s1_u;
    smp_t       s1_v;
    logic       s2_valid;
    acc_t       s2_a;
    acc_t       s2_b;
    acc_t       s2_c;
    acc_t       s2_d;
    acc_t       s2_e;
    acc_t       sum_r;
    acc_t       sum_g;
    acc_t       sum_b;
    logic [7:0] clip_r;
    logic [7:0] clip_g;
    logic [7:0] clip_b;
    logic       out_valid;
    logic [7:0] out_r;
    logic [7:0] out_g;
    logic [7:0] out_b;
    logic       out_xfer;
    logic [CNT_W-1:0] cnt;
    logic       done;

    // All stages move in lockstep; bubbles are carried, not squeezed out.
    assign advance      = ~out_valid | bus.out_ready;
    assign out_xfer     = out_valid & bus.out_ready;
    assign bus.in_ready = advance;

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            s1_valid <= 1'b0;
            s1_y     <= '0;
            s1_u     <= '0;
            s1_v     <= '0;
        end else if (advance) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_y <= centre(bus.in_Y, smp_t'(Y_OFS));
                s1_u <= centre(bus.in_U, smp_t'(C_OFS));
                s1_v <= centre(bus.in_V, smp_t'(C_OFS));
            end
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            s2_valid <= 1'b0;
            s2_a     <= '0;
            s2_b     <= '0;
            s2_c     <= '0;
            s2_d     <= '0;
            s2_e     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_a     <= acc_t'(COEF_Y)  * acc_t'(s1_y);
            s2_b     <= acc_t'(COEF_RV) * acc_t'(s1_v);
            s2_c     <= acc_t'(COEF_GU) * acc_t'(s1_u);
            s2_d     <= acc_t'(COEF_GV) * acc_t'(s1_v);
            s2_e     <= acc_t'(COEF_BU) * acc_t'(s1_u);
        end
    end

    always_comb begin
        sum_r = s2_a + s2_b;
        sum_g = s2_a - s2_c - s2_d;
        sum_b = s2_a + s2_e;
    end

    csc_clip_u8 u_clip_r (.sum(sum_r), .q(clip_r));
    csc_clip_u8 u_clip_g (.sum(sum_g), .q(clip_g));
    csc_clip_u8 u_clip_b (.sum(sum_b), .q(clip_b));

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_r <= clip_r;
                out_g <= clip_g;
                out_b <= clip_b;
            end
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (out_xfer && cnt == LAST) begin
            cnt  <= '0;
            done <= 1'b1;
        end else if (out_xfer) begin
            cnt  <= cnt + CNT_W'(1);
            done <= 1'b0;
        end else begin
            done <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid;
    assign bus.out_R       = out_r;
    assign bus.out_G       = out_g;
    assign bus.out_B       = out_b;
    assign bus.frame_done  = done;
    assign bus.pixel_count = cnt;
endmodule
